// File: rtl/serial_alu.sv
// Bit-serial accumulator/ALU: shifts A and a captured operand X through a 1-bit
// ALU over WIDTH clocks, then commits the result and carry/zero flags.
module serial_alu #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x_in,
    input  logic             wra,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] a,
    output logic             f,
    output logic             z,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        IDLE,
        SHIFT
    } state_t;

    typedef enum logic [2:0] {
        OP_NOR  = 3'b000,
        OP_ADD  = 3'b001,
        OP_ADC  = 3'b010,
        OP_SUB  = 3'b011,
        OP_SHR  = 3'b100,
        OP_LOAD = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } op_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] x_q, x_d;
    op_t              op_q, op_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             f_q, f_d;
    logic             z_q, z_d;
    logic             done_q, done_d;

    logic             last_step;
    logic             x_bit;
    logic             sum_bit;
    logic             carry_out;
    logic             r_bit;
    logic             c_step;
    logic [WIDTH-1:0] result;

    assign last_step = (cnt_q == CW'(WIDTH - 1));

    // One-bit datapath. SHR reads S[1] so bit k of the result is old a[k+1];
    // the final step inserts the incoming carry at the MSB.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        x_bit     = (op_q == OP_SUB) ? ~x_q[0] : x_q[0];
        sum_bit   = s_q[0] ^ x_bit ^ c_q;
        carry_out = (s_q[0] & x_bit) | (s_q[0] & c_q) | (x_bit & c_q);
        r_bit     = s_q[0];
        c_step    = c_q;
        unique case (op_q)
            OP_NOR:  r_bit = ~(s_q[0] | x_q[0]);
            OP_ADD,
            OP_ADC,
            OP_SUB: begin
                r_bit  = sum_bit;
                c_step = carry_out;
            end
            OP_SHR:  r_bit = last_step ? c_q : s_q[1];
            OP_LOAD: r_bit = x_q[0];
            default: r_bit = s_q[0];
        endcase
        result = {r_bit, s_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        x_d     = x_q;
        op_d    = op_q;
        c_d     = c_q;
        a_d     = a_q;
        f_d     = f_q;
        z_d     = z_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    s_d     = a_q;
                    x_d     = x_in;
                    op_d    = op_t'(op);
                    unique case (op_t'(op))
                        OP_ADC:  c_d = f_q;
                        OP_SUB:  c_d = 1'b1;
                        OP_SHR:  c_d = f_q;
                        default: c_d = 1'b0;
                    endcase
                end else if (wra) begin
                    a_d = d_in;
                    z_d = (d_in == '0);
                end
            end

            SHIFT: begin
                s_d   = result;
                x_d   = x_q >> 1;
                c_d   = c_step;
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    unique case (op_q)
                        OP_NOR,
                        OP_LOAD: begin
                            a_d = result;
                            z_d = (result == '0);
                        end
                        OP_ADD,
                        OP_ADC,
                        OP_SUB: begin
                            a_d = result;
                            f_d = c_step;
                            z_d = (result == '0);
                        end
                        OP_SHR: begin
                            // a is frozen during SHIFT, so a_q[0] is still the old LSB.
                            a_d = result;
                            f_d = a_q[0];
                            z_d = (result == '0);
                        end
                        default: ;
                    endcase
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: the internal S/X registers are reset along with the architectural
    // state so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            x_q     <= '0;
            op_q    <= OP_NOR;
            c_q     <= 1'b0;
            a_q     <= '0;
            f_q     <= 1'b0;
            z_q     <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            x_q     <= x_d;
            op_q    <= op_d;
            c_q     <= c_d;
            a_q     <= a_d;
            f_q     <= f_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    assign a    = a_q;
    assign f    = f_q;
    assign z    = z_q;
    assign busy = (state_q == SHIFT);
    assign done = done_q;

endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu at WIDTH=12, 16 and 2: stimulus pushes the
// expected commit, a monitor pops and compares on every done pulse.
module tb_serial_alu;

    typedef struct {
        int          sel;
        logic [15:0] a;
        logic        f;
        logic        z;
        string       name;
    } exp_t;

    logic clk;
    logic nrst;

    logic        start_v [3];
    logic [2:0]  op_v    [3];
    logic [15:0] x_v     [3];
    logic        wra_v   [3];
    logic [15:0] d_v     [3];

    logic [11:0] a12;
    logic [15:0] a16;
    logic [1:0]  a2;
    logic        f12, f16, f2, z12, z16, z2;
    logic        busy12, busy16, busy2, done12, done16, done2;

    logic [15:0] a_v    [3];
    logic        f_v    [3];
    logic        z_v    [3];
    logic        busy_v [3];
    logic        done_v [3];

    assign a_v[0] = {4'h0, a12};
    assign a_v[1] = a16;
    assign a_v[2] = {14'h0, a2};
    assign f_v[0] = f12;    assign f_v[1] = f16;    assign f_v[2] = f2;
    assign z_v[0] = z12;    assign z_v[1] = z16;    assign z_v[2] = z2;
    assign busy_v[0] = busy12; assign busy_v[1] = busy16; assign busy_v[2] = busy2;
    assign done_v[0] = done12; assign done_v[1] = done16; assign done_v[2] = done2;

    serial_alu #(.WIDTH(12)) u_alu12 (
        .clk(clk), .nrst(nrst), .start(start_v[0]), .op(op_v[0]), .x_in(x_v[0][11:0]),
        .wra(wra_v[0]), .d_in(d_v[0][11:0]), .a(a12), .f(f12), .z(z12),
        .busy(busy12), .done(done12)
    );
    serial_alu #(.WIDTH(16)) u_alu16 (
        .clk(clk), .nrst(nrst), .start(start_v[1]), .op(op_v[1]), .x_in(x_v[1]),
        .wra(wra_v[1]), .d_in(d_v[1]), .a(a16), .f(f16), .z(z16),
        .busy(busy16), .done(done16)
    );
    serial_alu #(.WIDTH(2)) u_alu2 (
        .clk(clk), .nrst(nrst), .start(start_v[2]), .op(op_v[2]), .x_in(x_v[2][1:0]),
        .wra(wra_v[2]), .d_in(d_v[2][1:0]), .a(a2), .f(f2), .z(z2),
        .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    logic [15:0] a_m [3];
    logic prev_done [3];

    localparam logic [2:0] NOR = 3'b000, ADD = 3'b001, ADC = 3'b010, SUB = 3'b011,
                           SHR = 3'b100, LOAD = 3'b101, RSV = 3'b111;

    function automatic int width_of(int s);
        return (s == 0) ? 12 : (s == 1) ? 16 : 2;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (done_v[s]) begin
                check("done_single_cycle", prev_done[s], 1'b0);
                if (sb_q.size() == 0) begin
                    check("done_without_start", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check({e.name, "/dut"}, s, e.sel);
                    check({e.name, "/a"}, a_v[s], e.a);
                    check({e.name, "/f"}, f_v[s], e.f);
                    check({e.name, "/z"}, z_v[s], e.z);
                end
            end
            prev_done[s] = done_v[s];
        end
    end

    task automatic wr(int s, logic [15:0] d, string name);
        @(negedge clk);
        wra_v[s] = 1'b1;
        d_v[s]   = d;
        @(negedge clk);
        wra_v[s] = 1'b0;
        check({name, "/a"}, a_v[s], d);
        check({name, "/z"}, z_v[s], (d == 16'h0));
        check({name, "/busy"}, busy_v[s], 1'b0);
        check({name, "/nodone"}, done_v[s], 1'b0);
        a_m[s] = d;
    endtask

    // Issues one op; b2b issues in the current (done) cycle. inject_at>0 drives
    // a LOAD start plus wra at that busy cycle, both of which must be ignored.
    task automatic run_op(int s, logic [2:0] opc, logic [15:0] x, logic [15:0] ea,
                          logic ef, logic ez, string name, bit b2b, int inject_at);
        int n;
        bit busy_ok;
        bit hold_ok;
        if (!b2b) @(negedge clk);
        start_v[s] = 1'b1;
        op_v[s]    = opc;
        x_v[s]     = x;
        sb_q.push_back('{sel: s, a: ea, f: ef, z: ez, name: name});
        n = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (!done_v[s]) begin
                if (busy_v[s] !== 1'b1) busy_ok = 1'b0;
                if (a_v[s] !== a_m[s]) hold_ok = 1'b0;
            end
            if (n == inject_at) begin
                start_v[s] = 1'b1;
                op_v[s]    = LOAD;
                x_v[s]     = 16'hFFFF;
                wra_v[s]   = 1'b1;
                d_v[s]     = 16'h0000;
            end else begin
                start_v[s] = 1'b0;
                wra_v[s]   = 1'b0;
            end
        end while (done_v[s] !== 1'b1 && n < 40);
        // Start is driven half a cycle before E0, so done is seen WIDTH+1 negedges later.
        check({name, "/latency"}, n, width_of(s) + 1);
        check({name, "/busy_during"}, busy_ok, 1'b1);
        check({name, "/a_hold"}, hold_ok, 1'b1);
        check({name, "/busy_at_done"}, busy_v[s], 1'b0);
        a_m[s] = ea;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  quiet;
        nrst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            start_v[s] = 1'b0; op_v[s] = 3'b000; x_v[s] = 16'h0;
            wra_v[s] = 1'b0; d_v[s] = 16'h0; a_m[s] = 16'h0; prev_done[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("reset/a", a_v[0], 16'h0);
        check("reset/f", f_v[0], 1'b0);
        check("reset/z", z_v[0], 1'b1);
        check("reset/busy", busy_v[0], 1'b0);
        check("reset/done", done_v[0], 1'b0);
        nrst = 1'b1;

        wr(0, 16'h07FF, "wr_7ff");
        run_op(0, ADD, 16'h001, 16'h800, 1'b0, 1'b0, "add_1", 1'b0, 0);
        run_op(0, ADD, 16'h800, 16'h000, 1'b1, 1'b1, "add_b2b", 1'b1, 0);
        run_op(0, ADC, 16'h000, 16'h001, 1'b0, 1'b0, "adc_cin", 1'b0, 0);
        run_op(0, SUB, 16'h003, 16'hFFE, 1'b0, 1'b0, "sub_borrow", 1'b0, 0);
        wr(0, 16'h0005, "wr_5");
        run_op(0, SUB, 16'h005, 16'h000, 1'b1, 1'b1, "sub_equal", 1'b0, 0);
        wr(0, 16'h00F0, "wr_0f0");
        run_op(0, NOR, 16'h00F, 16'hF00, 1'b1, 1'b0, "nor", 1'b0, 0);
        wr(0, 16'h0003, "wr_3");
        run_op(0, SHR, 16'h000, 16'h801, 1'b1, 1'b0, "shr_f1", 1'b0, 0);
        wr(0, 16'h0002, "wr_2");
        run_op(0, SHR, 16'h000, 16'h801, 1'b0, 1'b0, "shr_lsb0", 1'b0, 0);
        run_op(0, SHR, 16'h000, 16'h400, 1'b1, 1'b0, "shr_f0", 1'b0, 0);
        run_op(0, LOAD, 16'hABC, 16'hABC, 1'b1, 1'b0, "load", 1'b0, 0);
        run_op(0, RSV, 16'h123, 16'hABC, 1'b1, 1'b0, "reserved", 1'b0, 0);

        @(negedge clk);
        wra_v[0] = 1'b1;
        d_v[0]   = 16'h555;
        run_op(0, ADD, 16'h001, 16'hABD, 1'b0, 1'b0, "start_wins", 1'b1, 0);
        run_op(0, ADD, 16'h010, 16'hACD, 1'b0, 1'b0, "busy_ignore", 1'b0, 5);
        repeat (3) @(negedge clk);
        check("busy_ignore/a_after", a_v[0], 16'hACD);
        check("busy_ignore/idle", busy_v[0], 1'b0);

        // Abort an ADD part-way: nothing may commit and no done may follow.
        @(negedge clk);
        start_v[0] = 1'b1; op_v[0] = ADD; x_v[0] = 16'h001;
        repeat (5) begin
            @(negedge clk);
            start_v[0] = 1'b0;
        end
        nrst = 1'b0;
        #1;
        check("abort/a", a_v[0], 16'h0);
        check("abort/f", f_v[0], 1'b0);
        check("abort/z", z_v[0], 1'b1);
        check("abort/busy", busy_v[0], 1'b0);
        check("abort/done", done_v[0], 1'b0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        a_m[0] = 16'h0;
        quiet = 1'b1;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) quiet = 1'b0;
        end
        check("abort/quiet", quiet, 1'b1);
        run_op(0, ADD, 16'h00F, 16'h00F, 1'b0, 1'b0, "add_after_abort", 1'b0, 0);

        wr(1, 16'hFFFF, "w16_wr");
        run_op(1, ADD, 16'h0001, 16'h0000, 1'b1, 1'b1, "w16_add_wrap", 1'b0, 0);
        wr(2, 16'h0003, "w2_wr");
        run_op(2, ADD, 16'h0001, 16'h0000, 1'b1, 1'b1, "w2_add_wrap", 1'b0, 0);
        run_op(2, SUB, 16'h0001, 16'h0003, 1'b0, 1'b0, "w2_sub_borrow", 1'b0, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
